// File: rtl/cups_pkg.sv
// Shared types and constants for the fetch unit.
// Holds the FSM state enum, default widths and the ack-timeout limit.
package cups_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int WDT_W      = 4;
  localparam int WDT_LIMIT  = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_wdt.sv
// Ack watchdog for the fetch unit: counts REQ cycles without mem_ack.
// Only instantiated when FETCH_ACK_TIMEOUT_EN is defined.
module fetch_wdt
  import cups_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [WDT_W-1:0] cnt;

  // count unanswered request cycles, restarting on each new request
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = inc && (cnt == WDT_W'(WDT_LIMIT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE -> REQ -> HOLD handshake with memory/decode.
// Optional macro FETCH_ACK_TIMEOUT_EN enables the ack watchdog and fetch_err.
module fetch_unit
  import cups_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              stahp,
  input  logic              of,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] next_pc,
  output logic              pcdrive,
  output logic              fetch_err
);

  fetch_state_e state, state_nx;
  logic start, ack_ok, handoff, expired;

  // No fetch during the pcdrive cycle: pc_in still shows the old PC
  // until the load edge, so wait one cycle for the new value.
  assign start   = (state == IDLE) && !stahp && !of && !pcdrive;
  assign ack_ok  = (state == REQ) && mem_ack;
  assign handoff = (state == HOLD) && instr_ready && !stahp;

`ifdef FETCH_ACK_TIMEOUT_EN
  fetch_wdt u_wdt (
    .clk     (clk),
    .reset   (reset),
    .clr     (start),
    .inc     ((state == REQ) && !mem_ack),
    .expired (expired)
  );

  // sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_err <= 1'b0;
    end else if (expired) begin
      fetch_err <= 1'b1;
    end
  end
`else
  assign expired   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE): if (start) state_nx = REQ;
      (state == REQ): begin
        if (mem_ack) state_nx = HOLD;
        else if (expired) state_nx = IDLE;
      end
      (state == HOLD): if (handoff) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    mem_req     = (state == REQ);
    instr_valid = (state == HOLD);
  end

  // address, instruction and PC-load registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr <= '0;
      instr    <= '0;
      next_pc  <= '0;
      pcdrive  <= 1'b0;
    end else begin
      pcdrive <= handoff;
      if (start) mem_addr <= pc_in;
      if (ack_ok) instr <= mem_rdata;
      if (handoff) begin
        next_pc <= branch_taken ? branch_target
                                : mem_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// fetches checked against a transaction-level expectation model.
module tb_fetch_unit;
  import cups_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc_in;
  logic          stahp;
  logic          of;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [AW-1:0] next_pc;
  logic          pcdrive;
  logic          fetch_err;

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_in         (pc_in),
    .stahp         (stahp),
    .of            (of),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .next_pc       (next_pc),
    .pcdrive       (pcdrive),
    .fetch_err     (fetch_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [AW-1:0] pc = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete fetch: request, ack after dly cycles, stall cycles in
  // HOLD, then hand-off. Inputs change at negedge; outputs sampled there.
  task automatic fetch(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input int dly, input int stall, input bit br,
                       input logic [AW-1:0] tgt, output int req_cyc);
    logic [AW-1:0] exp_pc;
    pc_in = addr; stahp = 0; of = 0; mem_ack = 0;
    instr_ready = 0; branch_taken = 0;
    @(negedge clk);
    req_cyc = cyc;
    chk("req_up", mem_req, 1);
    chk("req_addr", mem_addr, addr);
    for (int k = 0; k < dly; k++) begin
      mem_ack = 0; mem_rdata = DW'($urandom);
      stahp = 1'($urandom_range(0, 1));
      of = 1'($urandom_range(0, 1));
      pc_in = AW'($urandom);
      @(negedge clk);
      chk("req_hold", mem_req, 1);
      chk("addr_hold", mem_addr, addr);
      chk("no_valid", instr_valid, 0);
    end
    stahp = 0; of = 0; mem_ack = 1; mem_rdata = data;
    @(negedge clk);
    chk("req_drop", mem_req, 0);
    chk("valid_up", instr_valid, 1);
    chk("instr", instr, data);
    for (int k = 0; k < stall; k++) begin
      instr_ready = 1'($urandom_range(0, 1));
      stahp = instr_ready ? 1'b1 : 1'($urandom_range(0, 1));
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = DW'($urandom);
      branch_taken = 1'($urandom_range(0, 1));
      branch_target = AW'($urandom);
      @(negedge clk);
      chk("valid_hold", instr_valid, 1);
      chk("instr_hold", instr, data);
      chk("no_pcdrive", pcdrive, 0);
    end
    exp_pc = br ? tgt : addr + 1'b1;
    instr_ready = 1; stahp = 0; mem_ack = 0;
    branch_taken = br; branch_target = tgt;
    @(negedge clk);
    chk("pcdrive", pcdrive, 1);
    chk("next_pc", next_pc, exp_pc);
    chk("valid_drop", instr_valid, 0);
    pc = exp_pc; pc_in = pc; instr_ready = 0;
    branch_taken = 1'($urandom_range(0, 1));
    branch_target = AW'($urandom);
    mem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("pcdrive_1cyc", pcdrive, 0);
    chk("next_pc_hold", next_pc, exp_pc);
    chk("req_gap", mem_req, 0);
    mem_ack = 0; branch_taken = 0;
  endtask

  initial begin
    int rc, rc1, rc2;
    reset = 1; pc_in = '0; stahp = 0; of = 0; branch_taken = 0;
    branch_target = '0; mem_ack = 0; mem_rdata = '0; instr_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_instr", instr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_npc", next_pc, 0);
    chk("rst_pcdrv", pcdrive, 0);
    chk("rst_err", fetch_err, 0);
    reset = 0;

    fetch(16'h0010, 16'hA5A5, 0, 0, 0, 16'h0000, rc);
    fetch(16'hFFFF, 16'h1234, 1, 0, 0, 16'h0000, rc);
    fetch(16'h0123, 16'h5A5A, 2, 1, 1, 16'h0200, rc);
    fetch(16'h0200, 16'hC3C3, 0, 6, 0, 16'h0000, rc);

    fetch(pc, 16'h1111, 0, 0, 0, 16'h0000, rc1);
    fetch(pc, 16'h2222, 0, 0, 0, 16'h0000, rc2);
    chk("throughput", rc2 - rc1, 4);

    of = 1; pc_in = 16'h0700;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("of_block", mem_req, 0);
    end
    of = 0; stahp = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stahp_block", mem_req, 0);
    end

    stahp = 0; pc_in = 16'h0300;
    @(negedge clk);
    chk("mid_req", mem_req, 1);
    reset = 1;
    @(negedge clk);
    chk("mid_rst_drop", mem_req, 0);
    reset = 0; of = 1; mem_ack = 1; mem_rdata = 16'hBEEF;
    @(negedge clk);
    chk("late_ack_valid", instr_valid, 0);
    chk("late_ack_instr", instr, 0);
    chk("late_ack_req", mem_req, 0);
    mem_ack = 0;

`ifdef FETCH_ACK_TIMEOUT_EN
    of = 0; pc_in = 16'h0400;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk("wdt_req", mem_req, 1);
      if (k == 1) of = 1;
    end
    @(negedge clk);
    chk("wdt_drop", mem_req, 0);
    chk("wdt_err", fetch_err, 1);
    repeat (5) @(negedge clk);
    chk("wdt_sticky", fetch_err, 1);
    reset = 1;
    @(negedge clk);
    chk("wdt_rst", fetch_err, 0);
    reset = 0;
`else
    fetch(pc, 16'h7E7E, 20, 0, 0, 16'h0000, rc);
    chk("no_err", fetch_err, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      int idle;
      fetch(pc, DW'($urandom), $urandom_range(0, 5), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), AW'($urandom), rc);
      idle = $urandom_range(0, 2);
      for (int k = 0; k < idle; k++) begin
        of = 1'($urandom_range(0, 1));
        stahp = !of;
        mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("rnd_block", mem_req, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
